// File: rtl/gelato_warp_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gelato_warp_scheduler_pkg: shared instruction/warp-id types           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gelato_warp_scheduler_pkg;

  localparam int NUM_WARPS_DEF = 4;
  localparam int WID_W_DEF     = $clog2(NUM_WARPS_DEF);

  typedef logic [31:0]          inst_t;
  typedef logic [WID_W_DEF-1:0] wid_t;

endpackage
`default_nettype wire

// File: rtl/gelato_warp_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gelato_warp_scheduler_if: valid/ready issue channel toward issue     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface gelato_warp_scheduler_if
  import gelato_warp_scheduler_pkg::*;
#(
  parameter int WID_W = WID_W_DEF
);

  logic             issue_valid;
  logic             issue_ready;
  inst_t            issue_inst;
  logic [WID_W-1:0] issue_wid;

  modport master (output issue_valid, output issue_inst, output issue_wid, input  issue_ready);
  modport slave  (input  issue_valid, input  issue_inst, input  issue_wid, output issue_ready);

endinterface
`default_nettype wire

// File: rtl/gelato_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gelato_rr_arbiter: combinational round-robin picker starting at ptr  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gelato_rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] grant_idx_o,
  output logic         any_grant_o
);

  logic [W-1:0] idx;

  // N is a power of two, so the W-bit add wraps the search order naturally
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_i + W'(k);
      if (!any_grant_o && req_i[idx]) begin
        any_grant_o  = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gelato_warp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gelato_warp_scheduler: round-robin warp pick into one issue register |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gelato_warp_scheduler
  import gelato_warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEF,
  parameter int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic [NUM_WARPS-1:0] buf_empty,
  input  inst_t                buf_tail_data [NUM_WARPS],
  output logic [NUM_WARPS-1:0] buf_pop,
  input  logic [NUM_WARPS-1:0] sb_ready,
  input  logic                 launch_valid,
  input  logic [WID_W-1:0]     launch_wid,
  input  logic                 exit_valid,
  input  logic [WID_W-1:0]     exit_wid,
  gelato_warp_scheduler_if.master iss,
  output logic [NUM_WARPS-1:0] active_mask,
  output logic [31:0]          perf_issue_cnt
);

  logic                 issue_valid_q, issue_valid_d;
  inst_t                issue_inst_q,  issue_inst_d;
  logic [WID_W-1:0]     issue_wid_q,   issue_wid_d;
  logic [WID_W-1:0]     rr_ptr_q,      rr_ptr_d;
  logic [NUM_WARPS-1:0] active_q,      active_d;
  logic [31:0]          perf_cnt_q,    perf_cnt_d;

  logic [NUM_WARPS-1:0] exiting, launching, eligible, req, grant;
  logic [WID_W-1:0]     grant_idx;
  logic                 any_grant, slot_free, accept;

  always_comb begin
    exiting   = '0;
    launching = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      exiting[i]   = exit_valid   && (exit_wid   == WID_W'(i));
      launching[i] = launch_valid && (launch_wid == WID_W'(i));
    end
  end

  // A warp exiting this cycle is already out of contention
  assign eligible  = active_q & ~buf_empty & sb_ready & ~exiting;
  assign slot_free = ~issue_valid_q | iss.issue_ready;
  assign req       = (rdy && slot_free) ? eligible : '0;
  assign accept    = rdy & issue_valid_q & iss.issue_ready;

  gelato_rr_arbiter #(
    .N (NUM_WARPS),
    .W (WID_W)
  ) u_arb (
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_inst_d  = issue_inst_q;
    issue_wid_d   = issue_wid_q;
    rr_ptr_d      = rr_ptr_q;
    active_d      = active_q;
    perf_cnt_d    = perf_cnt_q;
    buf_pop       = '0;
    if (rdy) begin
      if (accept) perf_cnt_d = perf_cnt_q + 32'd1;
      if (any_grant) begin
        buf_pop       = grant;
        issue_valid_d = 1'b1;
        issue_inst_d  = buf_tail_data[grant_idx];
        issue_wid_d   = grant_idx;
        rr_ptr_d      = grant_idx + WID_W'(1);
      end else if (accept) begin
        issue_valid_d = 1'b0;
      end
      // Clearing after setting lets exit win over a same-cycle launch
      active_d = (active_q | launching) & ~exiting;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_inst_q  <= '0;
      issue_wid_q   <= '0;
      rr_ptr_q      <= '0;
      active_q      <= '0;
      perf_cnt_q    <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_inst_q  <= issue_inst_d;
      issue_wid_q   <= issue_wid_d;
      rr_ptr_q      <= rr_ptr_d;
      active_q      <= active_d;
      perf_cnt_q    <= perf_cnt_d;
    end
  end

  assign iss.issue_valid = issue_valid_q;
  assign iss.issue_inst  = issue_inst_q;
  assign iss.issue_wid   = issue_wid_q;
  assign active_mask     = active_q;
  assign perf_issue_cnt  = perf_cnt_q;

  a_pop_only_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    (buf_pop & buf_empty) == '0);

endmodule
`default_nettype wire
